uart_tx_top: RTL

UART_TX_TOP -- requirements
Module: uart_tx_top

---
 rtl/uart_tx_top_if.sv | 18 +
 rtl/uart_tx_top.sv | 92 +++++++++
 2 files changed

// File: rtl/uart_tx_top_if.sv
// uart_tx_top_if: parallel request / serial line bundle for the UART transmitter
interface uart_tx_top_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PARITY_EN;
    logic                  PAR_TYP;
    logic                  TX_tick;
    logic                  TX_OUT;
    logic                  BUSY;
    modport master (
        output P_DATA, DATA_VALID, PARITY_EN, PAR_TYP, TX_tick,
        input  TX_OUT, BUSY
    );
    modport slave (
        input  P_DATA, DATA_VALID, PARITY_EN, PAR_TYP, TX_tick,
        output TX_OUT, BUSY
    );
endinterface

// File: rtl/uart_tx_top.sv
// uart_tx_top: tick-paced UART frame serializer (start, LSB-first data, optional parity, stop)
module uart_tx_top #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_top_if.slave   bus
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_e;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic [CW-1:0]         cnt_nxt;
    logic                  last_bit;
    logic                  parity;
    assign cnt_nxt  = cnt_q + CW'(1);
    assign last_bit = cnt_q == CW'(DATA_WIDTH - 1);
    assign parity   = (^data_q) ^ par_typ_q;
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: if (bus.DATA_VALID) begin
                state_d   = LOAD;
                busy_d    = 1'b1;
                data_d    = bus.P_DATA;
                par_en_d  = bus.PARITY_EN;
                par_typ_d = bus.PAR_TYP;
            end
            LOAD: if (bus.TX_tick) begin
                state_d = START;
                tx_d    = 1'b0;
            end
            START: if (bus.TX_tick) begin
                state_d = DATA;
                cnt_d   = '0;
                tx_d    = data_q[0];
            end
            // the tick that would index past the MSB leaves DATA instead
            DATA: if (bus.TX_tick) begin
                state_d = last_bit ? (par_en_q ? PARITY : STOP) : DATA;
                cnt_d   = last_bit ? cnt_q : cnt_nxt;
                tx_d    = last_bit ? (par_en_q ? parity : 1'b1) : data_q[cnt_nxt];
            end
            PARITY: if (bus.TX_tick) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
            STOP: if (bus.TX_tick) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            cnt_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end
    assign bus.TX_OUT = tx_q;
    assign bus.BUSY   = busy_q;
endmodule
